trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_defs.sv | 31 +++
 rtl/except_check.sv | 58 +++++
 rtl/trap_ctrl.sv | 109 ++++++++++
 tb/tb_trap_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_defs.sv
// Shared trap definitions: mcause codes, the legal opcode set and the trap FSM
// state encoding. Used by the trap controller and the CSR file.
package trap_defs;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HANDLER = 2'd1,
      ST_FAULT   = 2'd2
   } trap_state_t;

   localparam logic [31:0] CAUSE_INSTR_MISALIGNED = 32'd0;
   localparam logic [31:0] CAUSE_INSTR_FAULT      = 32'd1;
   localparam logic [31:0] CAUSE_ILLEGAL_INSTR    = 32'd2;
   localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
   localparam logic [31:0] CAUSE_LOAD_FAULT       = 32'd5;
   localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
   localparam logic [31:0] CAUSE_STORE_FAULT      = 32'd7;

   // Interrupt causes are the interrupt flag plus (16 + channel index).
   localparam logic [31:0] IRQ_CAUSE_FLAG = 32'h8000_0000;
   localparam logic [31:0] IRQ_CAUSE_BASE = IRQ_CAUSE_FLAG | 32'd16;

   function automatic logic is_legal_opcode(input logic [6:0] op);
      case (op)
         7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
         7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: is_legal_opcode = 1'b1;
         default:                           is_legal_opcode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/except_check.sv
// Combinational synchronous-exception detector. Reports the highest-priority
// exception of the current instruction with its mcause and mtval values.
module except_check
   import trap_defs::*;
#(
   parameter int ROM_BYTES = 65536,
   parameter int RAM_BYTES = 65536
) (
   input  logic [15:0] pc,
   input  logic [31:0] instr,
   input  logic [15:0] mem_addr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   output logic        exc_valid,
   output logic [31:0] exc_cause,
   output logic [31:0] exc_tval
);

   localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);
   localparam logic [31:0] RAM_LIMIT = 32'(RAM_BYTES);

   logic [31:0] pc_ext;
   logic [31:0] addr_ext;

   assign pc_ext   = {16'h0000, pc};
   assign addr_ext = {16'h0000, mem_addr};

   always_comb begin
      exc_valid = 1'b1;
      exc_cause = '0;
      exc_tval  = '0;
      if (pc[1:0] != 2'b00) begin
         exc_cause = CAUSE_INSTR_MISALIGNED;
         exc_tval  = pc_ext;
      end else if (pc_ext >= ROM_LIMIT) begin
         exc_cause = CAUSE_INSTR_FAULT;
         exc_tval  = pc_ext;
      end else if (!is_legal_opcode(instr[6:0])) begin
         exc_cause = CAUSE_ILLEGAL_INSTR;
         exc_tval  = instr;
      end else if (mem_rd && mem_addr[1:0] != 2'b00) begin
         exc_cause = CAUSE_LOAD_MISALIGNED;
         exc_tval  = addr_ext;
      end else if (mem_rd && addr_ext >= RAM_LIMIT) begin
         exc_cause = CAUSE_LOAD_FAULT;
         exc_tval  = addr_ext;
      end else if (mem_wr && mem_addr[1:0] != 2'b00) begin
         exc_cause = CAUSE_STORE_MISALIGNED;
         exc_tval  = addr_ext;
      end else if (mem_wr && addr_ext >= RAM_LIMIT) begin
         exc_cause = CAUSE_STORE_FAULT;
         exc_tval  = addr_ext;
      end else begin
         exc_valid = 1'b0;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: takes exceptions and edge-triggered interrupts from IDLE,
// blocks nesting while in HANDLER, and locks into FAULT on a nested exception.
// The FSM state is visible through in_handler and halt.
module trap_ctrl
   import trap_defs::*;
#(
   parameter int NUM_IRQ   = 4,
   parameter int ROM_BYTES = 65536,
   parameter int RAM_BYTES = 65536
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_en,
   input  logic               mie,
   input  logic [15:0]        pc,
   input  logic [31:0]        instr,
   input  logic [15:0]        mem_addr,
   input  logic               mem_rd,
   input  logic               mem_wr,
   input  logic               mret,
   output logic               trap_req,
   output logic [31:0]        trap_cause,
   output logic [31:0]        trap_tval,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               in_handler,
   output logic               halt
);

   trap_state_t        state, state_nxt;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [4:0]         sel;
   logic               exc_valid;
   logic [31:0]        exc_cause;
   logic [31:0]        exc_tval;

   except_check #(
      .ROM_BYTES (ROM_BYTES),
      .RAM_BYTES (RAM_BYTES)
   ) u_except_check (
      .pc        (pc),
      .instr     (instr),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .exc_valid (exc_valid),
      .exc_cause (exc_cause),
      .exc_tval  (exc_tval)
   );

   assign irq_rise   = irq & ~irq_q;
   assign eligible   = pending & irq_en;
   assign in_handler = (state == ST_HANDLER);
   assign halt       = (state == ST_FAULT);

   // A fresh edge re-arms a channel even in the cycle it is acknowledged.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pending <= '0;
         irq_q   <= '0;
      end else begin
         state   <= state_nxt;
         pending <= (pending & ~irq_ack) | irq_rise;
         irq_q   <= irq;
      end
   end

   // Lowest-index eligible channel wins.
   always_comb begin
      sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) sel = 5'(i);
      end
   end

   always_comb begin
      state_nxt  = state;
      trap_req   = 1'b0;
      trap_cause = '0;
      trap_tval  = '0;
      irq_ack    = '0;
      case (state)
         ST_IDLE: begin
            if (exc_valid) begin
               trap_req   = 1'b1;
               trap_cause = exc_cause;
               trap_tval  = exc_tval;
               state_nxt  = ST_HANDLER;
            end else if (mie && |eligible) begin
               trap_req   = 1'b1;
               trap_cause = IRQ_CAUSE_BASE + {27'd0, sel};
               irq_ack    = NUM_IRQ'(1) << sel;
               state_nxt  = ST_HANDLER;
            end
         end
         ST_HANDLER: begin
            if (exc_valid)  state_nxt = ST_FAULT;
            else if (mret)  state_nxt = ST_IDLE;
         end
         ST_FAULT: state_nxt = ST_FAULT;
         default:  state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

   localparam int NUM_IRQ = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_IRQ-1:0] irq;
   logic [NUM_IRQ-1:0] irq_en;
   logic               mie;
   logic [15:0]        pc;
   logic [31:0]        instr;
   logic [15:0]        mem_addr;
   logic               mem_rd;
   logic               mem_wr;
   logic               mret;
   logic               trap_req;
   logic [31:0]        trap_cause;
   logic [31:0]        trap_tval;
   logic [NUM_IRQ-1:0] irq_ack;
   logic               in_handler;
   logic               halt;

   int vectors = 0;
   int errors  = 0;

   trap_ctrl #(
      .NUM_IRQ   (NUM_IRQ),
      .ROM_BYTES (32768),
      .RAM_BYTES (4096)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq),
      .irq_en     (irq_en),
      .mie        (mie),
      .pc         (pc),
      .instr      (instr),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mret       (mret),
      .trap_req   (trap_req),
      .trap_cause (trap_cause),
      .trap_tval  (trap_tval),
      .irq_ack    (irq_ack),
      .in_handler (in_handler),
      .halt       (halt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      pc       = 16'h0100;
      instr    = 32'h0000_0013;
      mem_addr = 16'h0000;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mret     = 1'b0;
      mie      = 1'b1;
      irq_en   = 4'hF;
   endtask

   task automatic leave_handler();
      mret = 1'b1;
      tick();
      mret = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      set_defaults();
      irq = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if ({trap_req, in_handler, halt, irq_ack} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got req=%b hnd=%b halt=%b ack=%b want all 0",
                  trap_req, in_handler, halt, irq_ack);
      end
      vectors++;
      if ({trap_cause, trap_tval} !== 64'h0) begin
         errors++;
         $display("FAIL reset_cause_tval: got %h/%h want 0/0", trap_cause, trap_tval);
      end
      mret = 1'b1;
      tick();
      mret = 1'b0;
      #1;
      vectors++;
      if (in_handler !== 1'b0 || halt !== 1'b0 || trap_req !== 1'b0) begin
         errors++;
         $display("FAIL mret_in_idle: got hnd=%b halt=%b req=%b want 0/0/0", in_handler, halt, trap_req);
      end
   endtask

   task automatic test_pc_misaligned();
      pc = 16'h0102;
      #1;
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'd0 || trap_tval !== 32'h102) begin
         errors++;
         $display("FAIL pc_misaligned: got req=%b cause=%h tval=%h want 1/0/102",
                  trap_req, trap_cause, trap_tval);
      end
      tick();
      pc = 16'h0100;
      #1;
      vectors++;
      if (in_handler !== 1'b1 || trap_req !== 1'b0 || trap_cause !== 32'd0) begin
         errors++;
         $display("FAIL enter_handler: got hnd=%b req=%b cause=%h want 1/0/0", in_handler, trap_req, trap_cause);
      end
      leave_handler();
      vectors++;
      if (in_handler !== 1'b0) begin
         errors++;
         $display("FAIL mret_return: got hnd=%b want 0", in_handler);
      end
   endtask

   typedef struct {
      logic [15:0] pc;
      logic [31:0] instr;
      logic [15:0] addr;
      logic        rd;
      logic        wr;
      logic        req;
      logic [31:0] cause;
      logic [31:0] tval;
   } exc_vec_t;

   task automatic test_exc_table();
      exc_vec_t v[12];
      v = '{
         '{16'h8000, 32'h0000_0013, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd1, 32'h8000},
         '{16'h7FFC, 32'h0000_0013, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0},
         '{16'h8002, 32'h0000_0013, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'h8002},
         '{16'h0100, 32'h1234_567F, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd2, 32'h1234_567F},
         '{16'h0100, 32'h0000_0013, 16'h0FFE, 1'b1, 1'b0, 1'b1, 32'd4, 32'h0FFE},
         '{16'h0100, 32'h0000_0003, 16'h1000, 1'b1, 1'b0, 1'b1, 32'd5, 32'h1000},
         '{16'h0100, 32'h0000_0023, 16'h0002, 1'b0, 1'b1, 1'b1, 32'd6, 32'h0002},
         '{16'h0100, 32'h0000_0023, 16'hFFFC, 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFC},
         '{16'h0100, 32'h0000_0003, 16'h1001, 1'b1, 1'b0, 1'b1, 32'd4, 32'h1001},
         '{16'h0100, 32'h0000_0003, 16'h1000, 1'b1, 1'b1, 1'b1, 32'd5, 32'h1000},
         '{16'h0100, 32'h0000_0023, 16'h0FFC, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0},
         '{16'h0102, 32'h0000_007F, 16'h1001, 1'b1, 1'b0, 1'b1, 32'd0, 32'h0102}
      };
      for (int i = 0; i < 12; i++) begin
         pc       = v[i].pc;
         instr    = v[i].instr;
         mem_addr = v[i].addr;
         mem_rd   = v[i].rd;
         mem_wr   = v[i].wr;
         #1;
         vectors++;
         if (trap_req !== v[i].req || trap_cause !== v[i].cause ||
             trap_tval !== v[i].tval || irq_ack !== 4'b0) begin
            errors++;
            $display("FAIL exc_vec%0d: got req=%b cause=%h tval=%h ack=%b want %b/%h/%h/0000",
                     i, trap_req, trap_cause, trap_tval, irq_ack, v[i].req, v[i].cause, v[i].tval);
         end
         tick();
         set_defaults();
         if (v[i].req) leave_handler();
      end
   endtask

   task automatic test_irq_single();
      irq = 4'b0100;
      #1;
      vectors++;
      if (trap_req !== 1'b0) begin
         errors++;
         $display("FAIL irq2_early: got req=%b want 0", trap_req);
      end
      tick();
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0012 || trap_tval !== 32'h0 || irq_ack !== 4'b0100) begin
         errors++;
         $display("FAIL irq2_take: got req=%b cause=%h tval=%h ack=%b want 1/80000012/0/0100",
                  trap_req, trap_cause, trap_tval, irq_ack);
      end
      tick();
      vectors++;
      if (in_handler !== 1'b1 || trap_req !== 1'b0 || irq_ack !== 4'b0) begin
         errors++;
         $display("FAIL irq2_handler: got hnd=%b req=%b ack=%b want 1/0/0000", in_handler, trap_req, irq_ack);
      end
      irq = '0;
      leave_handler();
      vectors++;
      if (trap_req !== 1'b0) begin
         errors++;
         $display("FAIL irq2_no_retake: got req=%b want 0", trap_req);
      end
   endtask

   task automatic test_irq_pair();
      irq = 4'b1010;
      tick();
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0011 || irq_ack !== 4'b0010) begin
         errors++;
         $display("FAIL pair_first: got req=%b cause=%h ack=%b want 1/80000011/0010", trap_req, trap_cause, irq_ack);
      end
      tick();
      mret = 1'b1;
      #1;
      vectors++;
      if (trap_req !== 1'b0 || irq_ack !== 4'b0) begin
         errors++;
         $display("FAIL pair_blocked_in_handler: got req=%b ack=%b want 0/0000", trap_req, irq_ack);
      end
      tick();
      mret = 1'b0;
      #1;
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0013 || irq_ack !== 4'b1000) begin
         errors++;
         $display("FAIL pair_second: got req=%b cause=%h ack=%b want 1/80000013/1000", trap_req, trap_cause, irq_ack);
      end
      tick();
      irq = '0;
      leave_handler();
      vectors++;
      if (trap_req !== 1'b0) begin
         errors++;
         $display("FAIL pair_drained: got req=%b want 0", trap_req);
      end
   endtask

   task automatic test_exc_over_irq();
      irq = 4'b0001;
      tick();
      pc = 16'h0102;
      #1;
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'd0 || irq_ack !== 4'b0) begin
         errors++;
         $display("FAIL exc_beats_irq: got req=%b cause=%h ack=%b want 1/0/0000", trap_req, trap_cause, irq_ack);
      end
      tick();
      pc = 16'h0100;
      leave_handler();
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0010 || irq_ack !== 4'b0001) begin
         errors++;
         $display("FAIL irq_kept_pending: got req=%b cause=%h ack=%b want 1/80000010/0001", trap_req, trap_cause, irq_ack);
      end
      tick();
      irq = '0;
      leave_handler();
   endtask

   task automatic test_irq_mask();
      mie = 1'b0;
      irq = 4'b0010;
      tick();
      vectors++;
      if (trap_req !== 1'b0) begin
         errors++;
         $display("FAIL mie_masks: got req=%b want 0", trap_req);
      end
      mie    = 1'b1;
      irq_en = 4'b1101;
      #1;
      vectors++;
      if (trap_req !== 1'b0) begin
         errors++;
         $display("FAIL irq_en_masks: got req=%b want 0", trap_req);
      end
      irq_en = 4'hF;
      #1;
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0011 || irq_ack !== 4'b0010) begin
         errors++;
         $display("FAIL unmask_take: got req=%b cause=%h ack=%b want 1/80000011/0010", trap_req, trap_cause, irq_ack);
      end
      tick();
      irq = '0;
      leave_handler();
   endtask

   task automatic test_set_wins();
      mie = 1'b0;
      irq = 4'b0001;
      tick();
      irq = 4'b0000;
      tick();
      irq = 4'b0001;
      mie = 1'b1;
      #1;
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0010 || irq_ack !== 4'b0001) begin
         errors++;
         $display("FAIL setwin_first: got req=%b cause=%h ack=%b want 1/80000010/0001", trap_req, trap_cause, irq_ack);
      end
      tick();
      leave_handler();
      vectors++;
      if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0010 || irq_ack !== 4'b0001) begin
         errors++;
         $display("FAIL setwin_rearmed: got req=%b cause=%h ack=%b want 1/80000010/0001", trap_req, trap_cause, irq_ack);
      end
      tick();
      irq = '0;
      leave_handler();
      vectors++;
      if (trap_req !== 1'b0) begin
         errors++;
         $display("FAIL setwin_cleared: got req=%b want 0", trap_req);
      end
   endtask

   task automatic test_fault();
      pc = 16'h0102;
      tick();
      pc = 16'h8000;
      #1;
      vectors++;
      if (trap_req !== 1'b0 || trap_cause !== 32'd0 || trap_tval !== 32'd0) begin
         errors++;
         $display("FAIL nested_exc_no_trap: got req=%b cause=%h tval=%h want 0/0/0", trap_req, trap_cause, trap_tval);
      end
      tick();
      vectors++;
      if (halt !== 1'b1 || in_handler !== 1'b0 || trap_req !== 1'b0) begin
         errors++;
         $display("FAIL enter_fault: got halt=%b hnd=%b req=%b want 1/0/0", halt, in_handler, trap_req);
      end
      set_defaults();
      mret = 1'b1;
      irq  = 4'b0100;
      tick();
      tick();
      mret = 1'b0;
      pc   = 16'h0102;
      #1;
      vectors++;
      if (halt !== 1'b1 || trap_req !== 1'b0 || irq_ack !== 4'b0) begin
         errors++;
         $display("FAIL fault_sticky: got halt=%b req=%b ack=%b want 1/0/0000", halt, trap_req, irq_ack);
      end
      set_defaults();
      irq = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if (halt !== 1'b0 || in_handler !== 1'b0 || trap_req !== 1'b0) begin
         errors++;
         $display("FAIL fault_reset: got halt=%b hnd=%b req=%b want 0/0/0", halt, in_handler, trap_req);
      end
   endtask

   task automatic test_reset_in_handler();
      pc = 16'h0102;
      tick();
      pc  = 16'h0100;
      irq = 4'b1000;
      tick();
      vectors++;
      if (in_handler !== 1'b1 || trap_req !== 1'b0) begin
         errors++;
         $display("FAIL pend3_in_handler: got hnd=%b req=%b want 1/0", in_handler, trap_req);
      end
      rst = 1'b1;
      irq = '0;
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if (in_handler !== 1'b0 || halt !== 1'b0) begin
         errors++;
         $display("FAIL handler_reset: got hnd=%b halt=%b want 0/0", in_handler, halt);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (trap_req !== 1'b0 || irq_ack !== 4'b0) begin
            errors++;
            $display("FAIL pending_flushed%0d: got req=%b ack=%b want 0/0000", i, trap_req, irq_ack);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_pc_misaligned();
      test_exc_table();
      test_irq_single();
      test_irq_pair();
      test_exc_over_irq();
      test_irq_mask();
      test_set_wins();
      test_fault();
      test_reset_in_handler();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
